// File: rtl/branch_resolve_bht.sv
// rtl/branch_resolve_bht.sv - RV32I branch resolver with direct-mapped 2-bit BHT
// Optional BHT_STATS_EN adds stat_branches/stat_taken/stat_mispredict counters.
module branch_resolve_bht #(
  parameter int         XLEN        = 32,
  parameter int         BHT_ENTRIES = 64,
  parameter int         IDX_W       = $clog2(BHT_ENTRIES),
  parameter logic [1:0] CNT_INIT    = 2'b01
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_valid,
  output logic            pred_taken,
  input  logic            ex_valid,
  input  logic            ex_branch,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_srca,
  input  logic [XLEN-1:0] ex_srcb,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  output logic            res_valid,
  output logic            res_taken,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
`ifdef BHT_STATS_EN
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_taken,
  output logic [31:0]     stat_mispredict,
`endif
  output logic            illegal_br
);

  logic [1:0]      bht_q [BHT_ENTRIES];
  logic            pred_valid_q, pred_taken_q;
  logic            res_valid_q, res_taken_q, mispredict_q, illegal_q;
  logic [XLEN-1:0] redirect_q;

  logic            resolve, cond_taken, cond_illegal, upd_en;
  logic [IDX_W-1:0] upd_idx, look_idx;
  logic [1:0]      cur_cnt, new_cnt, look_cnt;
  logic [XLEN-1:0] pc_plus4, redirect_d;

  always_comb begin
    cond_taken   = 1'b0;
    cond_illegal = 1'b0;
    case (ex_funct3)
      3'b000:  cond_taken = (ex_srca == ex_srcb);
      3'b001:  cond_taken = (ex_srca != ex_srcb);
      3'b100:  cond_taken = ($signed(ex_srca) <  $signed(ex_srcb));
      3'b101:  cond_taken = ($signed(ex_srca) >= $signed(ex_srcb));
      3'b110:  cond_taken = (ex_srca <  ex_srcb);
      3'b111:  cond_taken = (ex_srca >= ex_srcb);
      default: cond_illegal = 1'b1;
    endcase
  end

  assign resolve    = ex_valid & ex_branch;
  assign upd_en     = resolve & ~cond_illegal;
  assign pc_plus4   = ex_pc + {{(XLEN-3){1'b0}}, 3'b100};
  assign redirect_d = cond_taken ? ex_target : pc_plus4;
  assign upd_idx    = ex_pc[IDX_W+1:2];
  assign look_idx   = if_pc[IDX_W+1:2];
  assign cur_cnt    = bht_q[upd_idx];

  always_comb begin
    new_cnt = cur_cnt;
    if (cond_taken) begin
      if (cur_cnt != 2'b11) new_cnt = cur_cnt + 2'd1;
    end else begin
      if (cur_cnt != 2'b00) new_cnt = cur_cnt - 2'd1;
    end
  end

  // Write-first: a lookup colliding with this cycle's training sees the new value.
  assign look_cnt = (upd_en && (look_idx == upd_idx)) ? new_cnt : bht_q[look_idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= CNT_INIT;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      res_valid_q  <= 1'b0;
      res_taken_q  <= 1'b0;
      mispredict_q <= 1'b0;
      illegal_q    <= 1'b0;
      redirect_q   <= '0;
    end else begin
      if (upd_en) bht_q[upd_idx] <= new_cnt;
      pred_valid_q <= if_valid;
      pred_taken_q <= if_valid & look_cnt[1];
      res_valid_q  <= resolve;
      mispredict_q <= resolve & (cond_taken != ex_pred_taken);
      illegal_q    <= resolve & cond_illegal;
      if (resolve) begin
        res_taken_q <= cond_taken;
        redirect_q  <= redirect_d;
      end
    end
  end

`ifdef BHT_STATS_EN
  logic [31:0] stat_br_q, stat_tk_q, stat_mp_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_br_q <= '0;
      stat_tk_q <= '0;
      stat_mp_q <= '0;
    end else if (resolve) begin
      if (!cond_illegal)                stat_br_q <= stat_br_q + 32'd1;
      if (cond_taken)                   stat_tk_q <= stat_tk_q + 32'd1;
      if (cond_taken != ex_pred_taken)  stat_mp_q <= stat_mp_q + 32'd1;
    end
  end

  assign stat_branches   = stat_br_q;
  assign stat_taken      = stat_tk_q;
  assign stat_mispredict = stat_mp_q;
`endif

  assign pred_valid  = pred_valid_q;
  assign pred_taken  = pred_taken_q;
  assign res_valid   = res_valid_q;
  assign res_taken   = res_taken_q;
  assign mispredict  = mispredict_q;
  assign illegal_br  = illegal_q;
  assign redirect_pc = redirect_q;

endmodule

// File: tb/tb_branch_resolve_bht.sv
// tb/tb_branch_resolve_bht.sv - directed self-checking bench for branch_resolve_bht
module tb_branch_resolve_bht;
  logic        clk = 1'b0;
  logic        rst_n, if_valid, ex_valid, ex_branch, ex_pred_taken;
  logic [31:0] if_pc, ex_srca, ex_srcb, ex_pc, ex_target;
  logic [2:0]  ex_funct3;
  logic        pred_valid, pred_taken, res_valid, res_taken, mispredict, illegal_br;
  logic [31:0] redirect_pc;
`ifdef BHT_STATS_EN
  logic [31:0] stat_branches, stat_taken, stat_mispredict;
`endif
  int checks = 0;
  int errors = 0;

  branch_resolve_bht dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_pc(if_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_funct3(ex_funct3),
    .ex_srca(ex_srca), .ex_srcb(ex_srcb), .ex_pc(ex_pc), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .res_valid(res_valid), .res_taken(res_taken),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
`ifdef BHT_STATS_EN
    .stat_branches(stat_branches), .stat_taken(stat_taken), .stat_mispredict(stat_mispredict),
`endif
    .illegal_br(illegal_br)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_valid = 0; if_pc = 0; ex_valid = 0; ex_branch = 0; ex_funct3 = 0;
    ex_srca = 0; ex_srcb = 0; ex_pc = 0; ex_target = 0; ex_pred_taken = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    step();
    rst_n = 1;
  endtask

  task automatic br(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] pc, input logic [31:0] tgt, input logic pt);
    ex_valid = 1; ex_branch = 1; ex_funct3 = f3; ex_srca = a; ex_srcb = b;
    ex_pc = pc; ex_target = tgt; ex_pred_taken = pt;
  endtask

  // One lookup cycle with no resolve; returns the prediction.
  task automatic lookup(input logic [31:0] pc, output logic p);
    idle();
    if_valid = 1; if_pc = pc;
    step();
    p = pred_taken;
    idle();
  endtask

  task automatic test_reset();
    logic p;
    idle();
    rst_n = 0;
    if_valid = 1; if_pc = 32'h100;
    br(3'b000, 5, 5, 32'h100, 32'h80, 0);
    step();
    checks++; if (pred_valid !== 0) begin errors++; $display("FAIL reset_pred_valid got %b exp 0", pred_valid); end
    checks++; if (res_valid !== 0) begin errors++; $display("FAIL reset_res_valid got %b exp 0", res_valid); end
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_redirect got %h exp 0", redirect_pc); end
    rst_n = 1;
    lookup(32'h100, p);
    checks++; if (pred_valid !== 1) begin errors++; $display("FAIL lookup_pred_valid got %b exp 1", pred_valid); end
    checks++; if (p !== 0) begin errors++; $display("FAIL lookup_init got %b exp 0", p); end
    step();
    checks++; if (pred_valid !== 0) begin errors++; $display("FAIL idle_pred_valid got %b exp 0", pred_valid); end
  endtask

  task automatic test_beq();
    logic p;
    do_reset();
    br(3'b000, 5, 5, 32'h100, 32'h80, 0);
    step();
    idle();
    checks++; if (res_valid !== 1) begin errors++; $display("FAIL beq_res_valid got %b exp 1", res_valid); end
    checks++; if (res_taken !== 1) begin errors++; $display("FAIL beq_taken got %b exp 1", res_taken); end
    checks++; if (mispredict !== 1) begin errors++; $display("FAIL beq_mispredict got %b exp 1", mispredict); end
    checks++; if (redirect_pc !== 32'h80) begin errors++; $display("FAIL beq_redirect got %h exp 80", redirect_pc); end
    checks++; if (illegal_br !== 0) begin errors++; $display("FAIL beq_illegal got %b exp 0", illegal_br); end
    lookup(32'h100, p);
    checks++; if (p !== 1) begin errors++; $display("FAIL beq_trained got %b exp 1 (01->10)", p); end
  endtask

  task automatic test_conditions();
    logic [2:0]  f3 [8] = '{3'b100, 3'b110, 3'b001, 3'b101, 3'b111, 3'b000, 3'b101, 3'b111};
    logic [31:0] a  [8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 5, 1, 1, 5, 7, 7};
    logic [31:0] b  [8] = '{1, 1, 6, 32'hFFFFFFFF, 32'hFFFFFFFF, 6, 7, 7};
    logic        tk [8] = '{1, 0, 1, 1, 0, 0, 1, 1};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      br(f3[i], a[i], b[i], 32'h400, 32'h1000, 1);
      step();
      checks++; if (res_taken !== tk[i]) begin errors++; $display("FAIL cond%0d_taken got %b exp %b", i, res_taken, tk[i]); end
      checks++; if (redirect_pc !== (tk[i] ? 32'h1000 : 32'h404)) begin errors++; $display("FAIL cond%0d_redirect got %h exp %h", i, redirect_pc, tk[i] ? 32'h1000 : 32'h404); end
      checks++; if (mispredict !== !tk[i]) begin errors++; $display("FAIL cond%0d_mispredict got %b exp %b", i, mispredict, !tk[i]); end
    end
    idle();
  endtask

  task automatic test_saturation();
    logic p;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      br(3'b000, 1, 1, 32'h200, 32'h40, 1);
      step();
      checks++; if (res_valid !== 1) begin errors++; $display("FAIL b2b%0d_res_valid got %b exp 1", i, res_valid); end
    end
    br(3'b001, 1, 1, 32'h200, 32'h40, 1);
    step();
    lookup(32'h200, p);
    checks++; if (p !== 1) begin errors++; $display("FAIL sat_hi got %b exp 1 (11->10)", p); end
    br(3'b001, 1, 1, 32'h200, 32'h40, 1);
    step();
    lookup(32'h200, p);
    checks++; if (p !== 0) begin errors++; $display("FAIL sat_dec got %b exp 0 (10->01)", p); end
    for (int i = 0; i < 3; i++) begin
      br(3'b001, 1, 1, 32'h200, 32'h40, 0);
      step();
    end
    br(3'b000, 1, 1, 32'h200, 32'h40, 0);
    step();
    lookup(32'h200, p);
    checks++; if (p !== 0) begin errors++; $display("FAIL sat_lo got %b exp 0 (00->01)", p); end
    br(3'b000, 1, 1, 32'h200, 32'h40, 0);
    step();
    lookup(32'h200, p);
    checks++; if (p !== 1) begin errors++; $display("FAIL sat_lo_inc got %b exp 1 (01->10)", p); end
  endtask

  task automatic test_forward();
    do_reset();
    br(3'b000, 3, 3, 32'h300, 32'h0, 0);
    if_valid = 1; if_pc = 32'h300;
    step();
    checks++; if (pred_valid !== 1 || pred_taken !== 1) begin errors++; $display("FAIL fwd_same got v=%b t=%b exp v=1 t=1", pred_valid, pred_taken); end
    do_reset();
    br(3'b000, 3, 3, 32'h300, 32'h0, 0);
    if_valid = 1; if_pc = 32'h304;
    step();
    checks++; if (pred_taken !== 0) begin errors++; $display("FAIL fwd_other got %b exp 0", pred_taken); end
    idle();
  endtask

  task automatic test_illegal();
    logic p;
    do_reset();
    br(3'b000, 0, 0, 32'h100, 32'h20, 0);
    step();
    br(3'b010, 9, 9, 32'h100, 32'h20, 0);
    step();
    idle();
    checks++; if (res_valid !== 1 || illegal_br !== 1) begin errors++; $display("FAIL ill_flags got v=%b ill=%b exp 1 1", res_valid, illegal_br); end
    checks++; if (res_taken !== 0) begin errors++; $display("FAIL ill_taken got %b exp 0", res_taken); end
    checks++; if (redirect_pc !== 32'h104) begin errors++; $display("FAIL ill_redirect got %h exp 104", redirect_pc); end
    step();
    checks++; if (res_valid !== 0 || illegal_br !== 0 || mispredict !== 0) begin errors++; $display("FAIL idle_clear got v=%b ill=%b mp=%b exp 000", res_valid, illegal_br, mispredict); end
    checks++; if (redirect_pc !== 32'h104 || res_taken !== 0) begin errors++; $display("FAIL idle_hold got pc=%h t=%b exp 104 0", redirect_pc, res_taken); end
    lookup(32'h100, p);
    checks++; if (p !== 1) begin errors++; $display("FAIL ill_no_train got %b exp 1", p); end
    br(3'b011, 1, 2, 32'h100, 32'h20, 1);
    step();
    idle();
    checks++; if (illegal_br !== 1 || mispredict !== 1) begin errors++; $display("FAIL ill011 got ill=%b mp=%b exp 1 1", illegal_br, mispredict); end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    br(3'b110, 5, 1, 32'hFFFFFFFC, 32'h1234, 0);
    step();
    idle();
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL pc_wrap got %h exp 0", redirect_pc); end
  endtask

  task automatic test_reset_mid();
    logic p;
    do_reset();
    br(3'b000, 2, 2, 32'h100, 32'h80, 0);
    if_valid = 1; if_pc = 32'h100;
    step();
    rst_n = 0;
    step();
    checks++; if ({pred_valid, pred_taken, res_valid, res_taken, mispredict, illegal_br} !== 6'b0 || redirect_pc !== 32'h0)
      begin errors++; $display("FAIL mid_reset got %b%b%b%b%b%b pc=%h exp all 0", pred_valid, pred_taken, res_valid, res_taken, mispredict, illegal_br, redirect_pc); end
    rst_n = 1;
    lookup(32'h100, p);
    checks++; if (p !== 0) begin errors++; $display("FAIL mid_reset_bht got %b exp 0", p); end
  endtask

  initial begin
    rst_n = 0;
    idle();
    test_reset();
    test_beq();
    test_conditions();
    test_saturation();
    test_forward();
    test_illegal();
    test_pc_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
